uart_packet_rx: RTL and testbench
=================================

Name: uart_packet_rx

Overview:
- Parametrised successor of the controller's UART entry receiver.
- Runs entirely on the system clock. There is no separate UART clock; the block times each bit internally by counting system clocks.
- Deserialises frames from the asynchronous serial line into N_CH channel storage registers, filled in round-robin order. A packet-complete strobe fires once every channel is filled.
- Adds features the previous receiver lacked: majority-vote sampling, optional parity, framing-error detection, and idle-timeout resync. Sits between the serial input pin and the DRSSTC timing/config registers.

Parameters:
- CLKS_PER_BIT, 16, system clocks per serial bit; must be >= 4.
- DATA_W, 8, data bits per frame.
- N_CH, 2, number of storage channels per packet; must be >= 1.
- PARITY_EN, 0, 1 = one even-parity bit follows the data bits.
- MSB_FIRST, 1, 1 = first data bit on the wire is the MSB.
- IDLE_BITS, 32, idle-line bit times after which a partially received packet is abandoned.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- uart_data, input, 1, raw serial line; idles high.
- ch_data, output, N_CH*DATA_W, channel storage; channel k occupies bits [k*DATA_W +: DATA_W].
- ch_valid, output, N_CH, bit k set once channel k has been written in the current packet.
- frame_valid, output, 1, one-clock pulse per good frame.
- frame_err, output, 1, one-clock pulse on a framing, parity or start-glitch error.
- packet_done, output, 1, one-clock pulse when channel N_CH-1 is written.
- state, output, 3, FSM state.
- ch_ptr, output, clog2(N_CH) (minimum 1), index of the next channel to write.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - ch_data=0, ch_valid=0, all pulses 0, state=IDLE, ch_ptr=0.
  - All counters are cleared.
  - The synchroniser flops are preset to 1.
  - Reset asserted mid-frame aborts the frame with no pulses.
- Input conditioning: uart_data passes through a 2-flop synchroniser. All sampling below uses the synchronised signal.
- Sampling: each bit is resolved by a majority of 3 samples, taken at clock counts c-1, c and c+1 within the bit, where c = CLKS_PER_BIT/2 (integer).
- FSM encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- IDLE -> START on a synchronised falling edge. The bit counter is cleared on entry.
- START:
  - Majority-sampled 0 -> DATA at the end of the bit period.
  - Majority-sampled 1 -> IDLE immediately after the c+1 sample; frame_err pulses and ch_ptr is unchanged.
- DATA:
  - DATA_W bits are shifted in, in the order set by MSB_FIRST.
  - After the last bit: -> PARITY if PARITY_EN, else -> STOP.
- PARITY: the sampled bit must make the total count of 1s across data+parity even. A mismatch sets an internal error flag; the state still moves to STOP.
- STOP: the decision is made one clock after the c+1 sample, then the FSM returns to IDLE.
  - Good frame (stop=1 and no error flag):
    - ch_data[ch_ptr] is loaded, ch_valid[ch_ptr] is set and frame_valid pulses.
    - ch_ptr increments.
    - If ch_ptr was N_CH-1: packet_done pulses in the same cycle, ch_ptr wraps to 0, and ch_valid clears on the following clock.
  - Bad frame (stop=0 or error flag): frame_err pulses, ch_data is unchanged, ch_ptr=0 and ch_valid=0.
- Re-arming: the FSM returns to IDLE at mid-stop-bit. A new start edge is accepted from the next clock, which tolerates back-to-back frames with a shortened stop bit.
- Idle timeout: in IDLE with ch_ptr != 0, a counter runs while the line is high.
  - After IDLE_BITS*CLKS_PER_BIT clocks: ch_ptr=0, ch_valid=0, no pulse.
  - The counter clears on any start edge.
- Simultaneous events: the timeout expiring on the same clock as a start edge resolves in favour of the start edge; the timeout does not fire. frame_valid and frame_err are never asserted together.
- Widths: all counters are sized with $clog2 of their maximum count. There is no truncation on channel indexing.

Test Plan:
- Frames 0x2C then 0x4C, 8N1, MSB_FIRST, CLKS_PER_BIT=16, N_CH=2 -> ch_data={0x4C,0x2C}; frame_valid pulses twice; a single packet_done on the second stop; ch_ptr ends at 0.
- Frame 0x2C with stop bit 0 -> frame_err pulses once; ch_data stays 0; ch_ptr=0; no frame_valid.
- Line low for 4 clocks, then high -> START aborts to IDLE; frame_err pulses once; no data written.
- PARITY_EN=1, data 0x2C, parity bit 0 (odd total) -> frame_err. Same data with parity bit 1 -> frame_valid, and ch_data[0]=0x2C.
- One good frame 0x11, then line idle for 32 bit times, then frame 0x22 -> ch_ptr resets after the timeout; 0x22 lands in ch0; no packet_done.
- rst_n pulsed low during the DATA bits of a frame -> all outputs are immediately 0 and state=IDLE. The next complete frame 0x55 is received into ch0.

Source files
------------

// File: rtl/uart_packet_rx.sv
// Oversampling UART receiver that fills N_CH channel registers round-robin and
// strobes packet_done once the last channel of a packet has been written.
module uart_packet_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int N_CH         = 2,
    parameter int PARITY_EN    = 0,
    parameter int MSB_FIRST    = 1,
    parameter int IDLE_BITS    = 32,
    localparam int PTR_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     uart_data,
    output logic [N_CH*DATA_W-1:0]   ch_data,
    output logic [N_CH-1:0]          ch_valid,
    output logic                     frame_valid,
    output logic                     frame_err,
    output logic                     packet_done,
    output logic [2:0]               state,
    output logic [PTR_W-1:0]         ch_ptr
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);
    localparam int BI_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TO_MAX = IDLE_BITS * CLKS_PER_BIT;
    localparam int TO_W   = (TO_MAX > 1) ? $clog2(TO_MAX) : 1;
    localparam int C      = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] SMP0     = CNT_W'(C - 1);
    localparam logic [CNT_W-1:0] SMP1     = CNT_W'(C);
    localparam logic [CNT_W-1:0] SMP2     = CNT_W'(C + 1);
    localparam logic [CNT_W-1:0] DECIDE   = CNT_W'(C + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BI_W-1:0]  LAST_BIT = BI_W'(DATA_W - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_MAX - 1);
    localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(N_CH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state_q, state_n;

    logic              s1, s2, rx_prev;
    logic [CNT_W-1:0]  cnt;
    logic [BI_W-1:0]   bit_idx;
    logic [TO_W-1:0]   to_cnt;
    logic [DATA_W-1:0] shreg;
    logic              v0, v1, stop_bit, err, clr_pend;
    logic              rx, fall, maj, bit_end, timeout;
    logic              good, bad, abort, last_ch;

    assign rx      = s2;
    assign fall    = rx_prev & ~rx;
    assign maj     = (v0 & v1) | (v0 & rx) | (v1 & rx);
    assign bit_end = (cnt == LAST_CNT);
    assign last_ch = (ch_ptr == LAST_CH);
    assign state   = state_q;
    // A start edge always wins over an expiring idle timer.
    assign timeout = (state_q == IDLE) && (ch_ptr != '0) && rx && !fall && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        good    = 1'b0;
        bad     = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE:   if (fall) state_n = START;
            START: begin
                if (cnt == SMP2 && maj) begin
                    state_n = IDLE;
                    abort   = 1'b1;
                end else if (bit_end) begin
                    state_n = DATA;
                end
            end
            DATA:   if (bit_end && bit_idx == LAST_BIT) state_n = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY: if (bit_end) state_n = STOP;
            STOP: begin
                // Leave at mid-stop-bit so a following start edge is not missed.
                if (cnt == DECIDE) begin
                    state_n = IDLE;
                    if (stop_bit && !err) good = 1'b1;
                    else                  bad  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b1;
            s2       <= 1'b1;
            rx_prev  <= 1'b1;
            cnt      <= '0;
            bit_idx  <= '0;
            to_cnt   <= '0;
            shreg    <= '0;
            v0       <= 1'b1;
            v1       <= 1'b1;
            stop_bit <= 1'b0;
            err      <= 1'b0;
        end else begin
            s1      <= uart_data;
            s2      <= s1;
            rx_prev <= s2;

            if (state_q == IDLE || state_n == IDLE)   cnt <= '0;
            else if (bit_end && state_q != STOP)      cnt <= '0;
            else                                      cnt <= cnt + 1'b1;

            if (state_q != DATA) bit_idx <= '0;
            else if (bit_end)    bit_idx <= bit_idx + 1'b1;

            if (cnt == SMP0) v0 <= rx;
            if (cnt == SMP1) v1 <= rx;
            if (cnt == SMP2) begin
                case (state_q)
                    DATA:    shreg <= (MSB_FIRST != 0) ? DATA_W'({shreg, maj}) : DATA_W'({maj, shreg} >> 1);
                    PARITY:  if (^{shreg, maj}) err <= 1'b1;
                    STOP:    stop_bit <= maj;
                    default: ;
                endcase
            end
            if (state_q == IDLE) err <= 1'b0;

            if (state_q != IDLE || ch_ptr == '0 || fall || timeout) to_cnt <= '0;
            else if (rx)                                            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_data     <= '0;
            ch_valid    <= '0;
            ch_ptr      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            packet_done <= 1'b0;
            clr_pend    <= 1'b0;
        end else begin
            frame_valid <= good;
            frame_err   <= bad | abort;
            packet_done <= good & last_ch;
            clr_pend    <= good & last_ch;
            if (clr_pend) ch_valid <= '0;
            if (good) begin
                for (int k = 0; k < N_CH; k++) begin
                    if (ch_ptr == PTR_W'(k)) begin
                        ch_data[k*DATA_W +: DATA_W] <= shreg;
                        ch_valid[k]                 <= 1'b1;
                    end
                end
                ch_ptr <= last_ch ? '0 : ch_ptr + 1'b1;
            end else if (bad || timeout) begin
                ch_ptr   <= '0;
                ch_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Scoreboard bench: two receivers (8N1 and 8E1) driven by bit-level serial tasks.
module tb_uart_packet_rx;

    logic        clk, rst_n, uart0, uart1;
    logic [15:0] ch_data0, ch_data1;
    logic [1:0]  ch_valid0, ch_valid1;
    logic        fv0, fe0, pd0, fv1, fe1, pd1;
    logic [2:0]  state0, state1;
    logic [0:0]  ptr0, ptr1;

    uart_packet_rx u0 (
        .clk(clk), .rst_n(rst_n), .uart_data(uart0), .ch_data(ch_data0), .ch_valid(ch_valid0),
        .frame_valid(fv0), .frame_err(fe0), .packet_done(pd0), .state(state0), .ch_ptr(ptr0)
    );

    uart_packet_rx #(.PARITY_EN(1)) u1 (
        .clk(clk), .rst_n(rst_n), .uart_data(uart1), .ch_data(ch_data1), .ch_valid(ch_valid1),
        .frame_valid(fv1), .frame_err(fe1), .packet_done(pd1), .state(state1), .ch_ptr(ptr1)
    );

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         ch;
        bit         pd;
    } exp_t;

    exp_t q0[$], q1[$];
    exp_t e0, e1;
    int n_chk = 0, n_pass = 0, fv_cnt = 0, pd_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input bit ln, input bit err, input logic [7:0] d, input int ch, input bit pd);
        exp_t e;
        e.err = err; e.data = d; e.ch = ch; e.pd = pd;
        if (ln) q1.push_back(e);
        else    q0.push_back(e);
    endtask

    task automatic drive_bit(input bit ln, input bit b);
        if (ln) uart1 = b;
        else    uart0 = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send(input bit ln, input logic [7:0] d, input bit par_en, input bit par, input bit stop);
        drive_bit(ln, 1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(ln, d[i]);
        if (par_en) drive_bit(ln, par);
        drive_bit(ln, stop);
        if (ln) uart1 = 1'b1;
        else    uart0 = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (fv0 || fe0) begin
            chk("u0_excl", 32'(fv0 & fe0), 32'h0);
            if (q0.size() == 0) chk("u0_unexpected", 32'h1, 32'h0);
            else begin
                e0 = q0.pop_front();
                if (e0.err) chk("u0_kind_err", 32'(fe0), 32'h1);
                else begin
                    chk("u0_kind_valid", 32'(fv0), 32'h1);
                    chk("u0_data", 32'(ch_data0[e0.ch*8 +: 8]), 32'(e0.data));
                    chk("u0_chvalid", 32'(ch_valid0[e0.ch]), 32'h1);
                    chk("u0_pdone", 32'(pd0), 32'(e0.pd));
                end
            end
        end
        if (fv0) fv_cnt++;
        if (pd0) pd_cnt++;
    end

    always @(negedge clk) begin
        if (fv1 || fe1) begin
            chk("u1_excl", 32'(fv1 & fe1), 32'h0);
            if (q1.size() == 0) chk("u1_unexpected", 32'h1, 32'h0);
            else begin
                e1 = q1.pop_front();
                if (e1.err) chk("u1_kind_err", 32'(fe1), 32'h1);
                else begin
                    chk("u1_kind_valid", 32'(fv1), 32'h1);
                    chk("u1_data", 32'(ch_data1[e1.ch*8 +: 8]), 32'(e1.data));
                    chk("u1_pdone", 32'(pd1), 32'(e1.pd));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; uart0 = 1'b1; uart1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data",   32'(ch_data0), 32'h0);
        chk("rst_valid",  32'(ch_valid0), 32'h0);
        chk("rst_state",  32'(state0), 32'h0);
        chk("rst_ptr",    32'(ptr0), 32'h0);
        chk("rst_pulses", 32'({fv0, fe0, pd0}), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // two-channel packet
        push(0, 0, 8'h2C, 0, 0); send(0, 8'h2C, 0, 0, 1);
        push(0, 0, 8'h4C, 1, 1); send(0, 8'h4C, 0, 0, 1);
        repeat (20) @(negedge clk);
        chk("pkt_data",   32'(ch_data0), 32'h4C2C);
        chk("pkt_ptr",    32'(ptr0), 32'h0);
        chk("pkt_valid",  32'(ch_valid0), 32'h0);
        chk("pkt_fv_cnt", 32'(fv_cnt), 32'd2);
        chk("pkt_pd_cnt", 32'(pd_cnt), 32'd1);

        // even parity on the second receiver
        push(1, 1, 8'h00, 0, 0); send(1, 8'h2C, 1, 0, 1);
        push(1, 0, 8'h2C, 0, 0); send(1, 8'h2C, 1, 1, 1);
        repeat (10) @(negedge clk);
        chk("par_data", 32'(ch_data1[7:0]), 32'h2C);
        chk("par_ptr",  32'(ptr1), 32'h1);

        // bad stop bit
        do_reset();
        push(0, 1, 8'h00, 0, 0); send(0, 8'h2C, 0, 0, 0);
        repeat (10) @(negedge clk);
        chk("stop_data",  32'(ch_data0), 32'h0);
        chk("stop_ptr",   32'(ptr0), 32'h0);
        chk("stop_fv",    32'(fv_cnt), 32'd2);
        chk("stop_state", 32'(state0), 32'h0);

        // start glitch keeps the channel pointer
        push(0, 0, 8'h11, 0, 0); send(0, 8'h11, 0, 0, 1);
        push(0, 1, 8'h00, 0, 0);
        uart0 = 1'b0; repeat (4) @(negedge clk);
        uart0 = 1'b1; repeat (40) @(negedge clk);
        chk("glitch_ptr",   32'(ptr0), 32'h1);
        chk("glitch_state", 32'(state0), 32'h0);
        chk("glitch_data",  32'(ch_data0[7:0]), 32'h11);
        chk("glitch_fv",    32'(fv_cnt), 32'd3);

        // idle timeout abandons a partial packet
        do_reset();
        push(0, 0, 8'h11, 0, 0); send(0, 8'h11, 0, 0, 1);
        repeat (480) @(negedge clk);
        chk("to_before_ptr",   32'(ptr0), 32'h1);
        chk("to_before_valid", 32'(ch_valid0), 32'h1);
        repeat (40) @(negedge clk);
        chk("to_after_ptr",   32'(ptr0), 32'h0);
        chk("to_after_valid", 32'(ch_valid0), 32'h0);
        push(0, 0, 8'h22, 0, 0); send(0, 8'h22, 0, 0, 1);
        repeat (10) @(negedge clk);
        chk("to_data", 32'(ch_data0[7:0]), 32'h22);
        chk("to_pd",   32'(pd_cnt), 32'd1);
        chk("to_ptr",  32'(ptr0), 32'h1);

        // reset in the middle of the data bits
        uart0 = 1'b0; repeat (16) @(negedge clk);
        uart0 = 1'b1; repeat (40) @(negedge clk);
        chk("mid_state", 32'(state0), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data",   32'(ch_data0), 32'h0);
        chk("mid_rst_valid",  32'(ch_valid0), 32'h0);
        chk("mid_rst_state",  32'(state0), 32'h0);
        chk("mid_rst_ptr",    32'(ptr0), 32'h0);
        chk("mid_rst_pulses", 32'({fv0, fe0, pd0}), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        push(0, 0, 8'h55, 0, 0); send(0, 8'h55, 0, 0, 1);
        repeat (10) @(negedge clk);
        chk("post_rst_data", 32'(ch_data0), 32'h0055);
        chk("post_rst_ptr",  32'(ptr0), 32'h1);

        chk("sb0_empty", 32'(q0.size()), 32'h0);
        chk("sb1_empty", 32'(q1.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
